// File: rtl/branch_pkg.sv
// branch_pkg: definitions shared by the branch-resolution unit.
//   br_type_e          : branch/jump type encodings
//   DEFAULT_XLEN       : default operand and address width
//   DEFAULT_INST_BYTES : default fall-through increment
package branch_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_JAL  = 3'b001,
    BR_EQ   = 3'b010,
    BR_NE   = 3'b011,
    BR_LT   = 3'b100,
    BR_GE   = 3'b101,
    BR_LTU  = 3'b110,
    BR_GEU  = 3'b111
  } br_type_e;

  localparam int DEFAULT_XLEN       = 64;
  localparam int DEFAULT_INST_BYTES = 4;

endpackage

// File: rtl/branch_cmp.sv
// branch_cmp: combinational branch direction compare.
// Ports:
//   reg1    in  XLEN  rs1 operand
//   reg2    in  XLEN  rs2 operand
//   br_type in  3     branch type (see branch_pkg::br_type_e)
//   taken   out 1     resolved direction
module branch_cmp
  import branch_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic [XLEN-1:0] reg1,
  input  logic [XLEN-1:0] reg2,
  input  logic [2:0]      br_type,
  output logic            taken
);

  br_type_e brType;
  assign brType = br_type_e'(br_type);

  // The signed and unsigned orderings share operands but differ in how the
  // top bit is interpreted, so both are computed and selected by type.
  logic isEqual;
  logic isLessSigned;
  logic isLessUnsigned;

  assign isEqual        = (reg1 == reg2);
  assign isLessSigned   = ($signed(reg1) < $signed(reg2));
  assign isLessUnsigned = (reg1 < reg2);

  // Direction select: JAL is always taken, "none" never is.
  always_comb begin
    taken = 1'b0;
    case (brType)
      BR_NONE: taken = 1'b0;
      BR_JAL:  taken = 1'b1;
      BR_EQ:   taken = isEqual;
      BR_NE:   taken = !isEqual;
      BR_LT:   taken = isLessSigned;
      BR_GE:   taken = !isLessSigned;
      BR_LTU:  taken = isLessUnsigned;
      BR_GEU:  taken = !isLessUnsigned;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// branch_unit: pipelined branch-resolution unit for the execute stage.
// Resolves direction, generates target/fall-through addresses, detects
// misprediction against the front-end prediction and presents the result
// through a single valid/ready register stage with flush.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    squash the in-flight result and any request
//   in_valid / in_ready      request handshake (in_ready is combinational)
//   reg1, reg2, br_type      compare operands and branch type
//   pc, imm                  instruction address and sign-extended offset
//   pred_taken, pred_target  front-end prediction
//   out_valid / out_ready    result handshake
//   taken, target            resolved direction and pc + imm
//   mispredict, redirect_pc  redirect request and correct next pc
// Optional feature: define BRANCH_UNIT_STATS_EN to add the saturating
// counters stat_branches and stat_mispredicts.
module branch_unit
  import branch_pkg::*;
#(
  parameter int XLEN       = DEFAULT_XLEN,
  parameter int INST_BYTES = DEFAULT_INST_BYTES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] reg1,
  input  logic [XLEN-1:0] reg2,
  input  logic [2:0]      br_type,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] pred_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            taken,
  output logic [XLEN-1:0] target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc
`ifdef BRANCH_UNIT_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam logic [XLEN-1:0] InstInc = XLEN'(INST_BYTES);

  // Result register and valid flag
  logic            outValid_q;
  logic            taken_q,      taken_d;
  logic [XLEN-1:0] target_q,     target_d;
  logic            mispredict_q, mispredict_d;
  logic [XLEN-1:0] redirectPc_q, redirectPc_d;

  logic            accept;
  logic [XLEN-1:0] fallthru;

  branch_cmp #(
    .XLEN(XLEN)
  ) u_cmp (
    .reg1   (reg1),
    .reg2   (reg2),
    .br_type(br_type),
    .taken  (taken_d)
  );

  // Both adders wrap modulo 2^XLEN by simple truncation.
  assign target_d = pc + imm;
  assign fallthru = pc + InstInc;

  // A correct direction with a wrong target is still a redirect.
  assign mispredict_d = (taken_d != pred_taken) ||
                        (taken_d && pred_taken && (pred_target != target_d));
  assign redirectPc_d = taken_d ? target_d : fallthru;

  // Pass-through ready: a full stage can accept when its result drains now.
  assign in_ready = !outValid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Priority is reset > flush > accept > drain. Result fields only load on
  // accept, so they hold whenever the stage is empty or stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      outValid_q   <= 1'b0;
      taken_q      <= 1'b0;
      target_q     <= '0;
      mispredict_q <= 1'b0;
      redirectPc_q <= '0;
    end else if (flush) begin
      outValid_q   <= 1'b0;
    end else if (accept) begin
      outValid_q   <= 1'b1;
      taken_q      <= taken_d;
      target_q     <= target_d;
      mispredict_q <= mispredict_d;
      redirectPc_q <= redirectPc_d;
    end else if (out_ready) begin
      outValid_q   <= 1'b0;
    end
  end

  assign out_valid   = outValid_q;
  assign taken       = taken_q;
  assign target      = target_q;
  assign mispredict  = mispredict_q;
  assign redirect_pc = redirectPc_q;

`ifdef BRANCH_UNIT_STATS_EN
  // The counters need to know whether the held result was a real branch,
  // so the type class travels alongside the result.
  logic        isBranch_q;
  logic [31:0] statBranches_q;
  logic [31:0] statMispredicts_q;
  logic        resultDone;

  assign resultDone = outValid_q && out_ready && !flush && isBranch_q;

  // Saturating event counters, advanced on each completed branch result.
  always_ff @(posedge clk) begin
    if (rst) begin
      isBranch_q        <= 1'b0;
      statBranches_q    <= '0;
      statMispredicts_q <= '0;
    end else begin
      if (!flush && accept) begin
        isBranch_q <= (br_type != BR_NONE);
      end
      if (resultDone && (statBranches_q != 32'hFFFF_FFFF)) begin
        statBranches_q <= statBranches_q + 32'd1;
      end
      if (resultDone && mispredict_q && (statMispredicts_q != 32'hFFFF_FFFF)) begin
        statMispredicts_q <= statMispredicts_q + 32'd1;
      end
    end
  end

  assign stat_branches    = statBranches_q;
  assign stat_mispredicts = statMispredicts_q;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit: directed-vector bench for branch_unit.
// A 64-bit instance covers the main behaviour; a 32-bit instance sharing the
// same stimulus covers address wrap-around.
module tb_branch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [63:0] reg1, reg2, pc, imm, pred_target;
  logic [2:0]  br_type;
  logic        pred_taken;
  logic        out_ready;

  logic        in_ready, out_valid, taken, mispredict;
  logic [63:0] target, redirect_pc;

  logic        in_ready32, out_valid32, taken32, mispredict32;
  logic [31:0] target32, redirect_pc32;

`ifdef BRANCH_UNIT_STATS_EN
  logic [31:0] statBr, statMp, statBr32, statMp32;
`endif

  int vectorCount = 0;
  int missCount   = 0;

  always #5 clk = ~clk;

  branch_unit #(.XLEN(64), .INST_BYTES(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .reg1(reg1), .reg2(reg2), .br_type(br_type),
    .pc(pc), .imm(imm),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .taken(taken), .target(target),
    .mispredict(mispredict), .redirect_pc(redirect_pc)
`ifdef BRANCH_UNIT_STATS_EN
    , .stat_branches(statBr), .stat_mispredicts(statMp)
`endif
  );

  branch_unit #(.XLEN(32), .INST_BYTES(4)) dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32),
    .reg1(reg1[31:0]), .reg2(reg2[31:0]), .br_type(br_type),
    .pc(pc[31:0]), .imm(imm[31:0]),
    .pred_taken(pred_taken), .pred_target(pred_target[31:0]),
    .out_valid(out_valid32), .out_ready(out_ready),
    .taken(taken32), .target(target32),
    .mispredict(mispredict32), .redirect_pc(redirect_pc32)
`ifdef BRANCH_UNIT_STATS_EN
    , .stat_branches(statBr32), .stat_mispredicts(statMp32)
`endif
  );

  // Single comparison point: counts every vector and reports miscompares.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present one request with in_valid asserted.
  task automatic applyStimulus(input logic [2:0] t, input logic [63:0] r1,
                               input logic [63:0] r2, input logic [63:0] p,
                               input logic [63:0] im, input logic pt,
                               input logic [63:0] ptg);
    br_type     = t;
    reg1        = r1;
    reg2        = r2;
    pc          = p;
    imm         = im;
    pred_taken  = pt;
    pred_target = ptg;
    in_valid    = 1'b1;
  endtask

  // Advance one clock and sample just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] MINUS1 = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    br_type = 3'b000; reg1 = '0; reg2 = '0; pc = '0; imm = '0;
    pred_taken = 1'b0; pred_target = '0;

    // Reset state
    step(); step();
    checkOutput("rst_out_valid",   {63'd0, out_valid},   64'd0);
    checkOutput("rst_taken",       {63'd0, taken},       64'd0);
    checkOutput("rst_target",      target,               64'd0);
    checkOutput("rst_mispredict",  {63'd0, mispredict},  64'd0);
    checkOutput("rst_redirect_pc", redirect_pc,          64'd0);
    checkOutput("rst_in_ready",    {63'd0, in_ready},    64'd1);
    rst = 1'b0;

    // BLT -1 < 1 signed: taken, mispredicted as not-taken
    applyStimulus(3'b100, MINUS1, 64'd1, 64'h1000, 64'h20, 1'b0, 64'd0);
    step();
    checkOutput("blt_out_valid",  {63'd0, out_valid},  64'd1);
    checkOutput("blt_taken",      {63'd0, taken},      64'd1);
    checkOutput("blt_target",     target,              64'h1020);
    checkOutput("blt_mispredict", {63'd0, mispredict}, 64'd1);
    checkOutput("blt_redirect",   redirect_pc,         64'h1020);

    // BLTU: 0xFFFF... is not below 1 unsigned
    applyStimulus(3'b110, MINUS1, 64'd1, 64'h1000, 64'h20, 1'b0, 64'd0);
    step();
    checkOutput("bltu_taken",      {63'd0, taken},      64'd0);
    checkOutput("bltu_target",     target,              64'h1020);
    checkOutput("bltu_mispredict", {63'd0, mispredict}, 64'd0);
    checkOutput("bltu_redirect",   redirect_pc,         64'h1004);

    // JAL with correct target prediction, then wrong target
    applyStimulus(3'b001, 64'd0, 64'd0, 64'h1000, 64'h1000, 1'b1, 64'h2000);
    step();
    checkOutput("jal_taken",      {63'd0, taken},      64'd1);
    checkOutput("jal_mispredict", {63'd0, mispredict}, 64'd0);
    checkOutput("jal_redirect",   redirect_pc,         64'h2000);
    applyStimulus(3'b001, 64'd0, 64'd0, 64'h1000, 64'h1000, 1'b1, 64'h2004);
    step();
    checkOutput("jal_bad_tgt_mispredict", {63'd0, mispredict}, 64'd1);

    // Remaining compare types
    applyStimulus(3'b010, 64'd5, 64'd5, 64'h100, 64'h40, 1'b1, 64'h140);
    step();
    checkOutput("beq_taken",      {63'd0, taken},      64'd1);
    checkOutput("beq_mispredict", {63'd0, mispredict}, 64'd0);
    applyStimulus(3'b011, 64'd5, 64'd6, 64'h100, 64'h40, 1'b0, 64'd0);
    step();
    checkOutput("bne_taken", {63'd0, taken}, 64'd1);
    applyStimulus(3'b101, MINUS1, 64'd1, 64'h100, 64'h40, 1'b1, 64'h140);
    step();
    checkOutput("bge_taken",      {63'd0, taken},      64'd0);
    checkOutput("bge_mispredict", {63'd0, mispredict}, 64'd1);
    checkOutput("bge_redirect",   redirect_pc,         64'h104);
    applyStimulus(3'b111, MINUS1, 64'd1, 64'h100, 64'h40, 1'b0, 64'd0);
    step();
    checkOutput("bgeu_taken", {63'd0, taken}, 64'd1);
    applyStimulus(3'b000, 64'd3, 64'd3, 64'h200, 64'h40, 1'b0, 64'd0);
    step();
    checkOutput("none_taken",      {63'd0, taken},      64'd0);
    checkOutput("none_mispredict", {63'd0, mispredict}, 64'd0);
    checkOutput("none_redirect",   redirect_pc,         64'h204);

    // Backpressure: A loads, then B waits three cycles behind a stalled A
    applyStimulus(3'b010, 64'd7, 64'd7, 64'h3000, 64'h10, 1'b1, 64'h3010);
    step();
    out_ready = 1'b0;
    applyStimulus(3'b011, 64'd7, 64'd7, 64'h4000, 64'h10, 1'b0, 64'd0);
    #1;
    checkOutput("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("bp_hold_valid",    {63'd0, out_valid}, 64'd1);
      checkOutput("bp_hold_target",   target,             64'h3010);
      checkOutput("bp_hold_taken",    {63'd0, taken},     64'd1);
      checkOutput("bp_hold_in_ready", {63'd0, in_ready},  64'd0);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp_in_ready_pass", {63'd0, in_ready}, 64'd1);
    step();
    checkOutput("bp_b_valid",    {63'd0, out_valid}, 64'd1);
    checkOutput("bp_b_target",   target,             64'h4010);
    checkOutput("bp_b_redirect", redirect_pc,        64'h4004);
    applyStimulus(3'b001, 64'd0, 64'd0, 64'h4004, 64'h100, 1'b1, 64'h4104);
    step();
    checkOutput("bp_c_valid",  {63'd0, out_valid}, 64'd1);
    checkOutput("bp_c_target", target,             64'h4104);
    in_valid = 1'b0;
    step();
    checkOutput("drain_valid",       {63'd0, out_valid}, 64'd0);
    checkOutput("drain_hold_target", target,             64'h4104);

    // Flush while full with a new request: result killed, request dropped
    applyStimulus(3'b010, 64'd1, 64'd1, 64'h5000, 64'h8, 1'b1, 64'h5008);
    step();
    checkOutput("fl_pre_valid", {63'd0, out_valid}, 64'd1);
    applyStimulus(3'b001, 64'd0, 64'd0, 64'h6000, 64'h80, 1'b0, 64'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    checkOutput("fl_valid",  {63'd0, out_valid}, 64'd0);
    checkOutput("fl_target", target,             64'h5008);
    step();
    checkOutput("fl_dropped", {63'd0, out_valid}, 64'd0);

    // Reset mid-stream
    applyStimulus(3'b001, 64'd0, 64'd0, 64'h7000, 64'h10, 1'b0, 64'd0);
    step();
    checkOutput("mr_pre_valid", {63'd0, out_valid}, 64'd1);
    rst = 1'b1;
    step();
    checkOutput("mr_valid",      {63'd0, out_valid},  64'd0);
    checkOutput("mr_taken",      {63'd0, taken},      64'd0);
    checkOutput("mr_target",     target,              64'd0);
    checkOutput("mr_mispredict", {63'd0, mispredict}, 64'd0);
    checkOutput("mr_redirect",   redirect_pc,         64'd0);
    rst = 1'b0;

    // Wrap-around on the 32-bit instance
    applyStimulus(3'b010, 64'd9, 64'd9, 64'hFFFF_FFFC, 64'd8, 1'b0, 64'd0);
    step();
    checkOutput("wrap_taken",    {63'd0, taken32},      64'd1);
    checkOutput("wrap_target",   {32'd0, target32},     64'h4);
    checkOutput("wrap_redirect", {32'd0, redirect_pc32}, 64'h4);
    checkOutput("wide_target",   target,                64'h1_0000_0004);
    applyStimulus(3'b011, 64'd9, 64'd9, 64'hFFFF_FFFC, 64'd8, 1'b0, 64'd0);
    step();
    checkOutput("wrap_nt_taken",    {63'd0, taken32},       64'd0);
    checkOutput("wrap_nt_redirect", {32'd0, redirect_pc32}, 64'h0);
    checkOutput("wrap_nt_mispred",  {63'd0, mispredict32},  64'd0);
    in_valid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
